// File: rtl/rf_wb_ctrl.sv
// Register-file write-side controller: arbitrates ALU (A) and variable-latency (B) results onto
// the RF write port and tracks pending destinations. Optional macro: RF_WB_EARLY_CLR_EN.
module rf_wb_ctrl #(
  parameter int STARVE_LIM = 4,
  parameter int CNT_W      = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_iss_valid,
  input  logic [4:0]  i_iss_rd,
  input  logic [4:0]  i_rs1_raddr,
  output logic        o_rs1_busy,
  input  logic [4:0]  i_rs2_raddr,
  output logic        o_rs2_busy,
  input  logic        i_a_valid,
  output logic        o_a_ready,
  input  logic [4:0]  i_a_waddr,
  input  logic [31:0] i_a_wdata,
  input  logic        i_b_valid,
  output logic        o_b_ready,
  input  logic [4:0]  i_b_waddr,
  input  logic [31:0] i_b_wdata,
  output logic        o_rd_wen,
  output logic [4:0]  o_rd_waddr,
  output logic [31:0] o_rd_wdata,
  output logic        o_wb_unexp
);

  localparam logic [CNT_W-1:0] LIM_C = CNT_W'(STARVE_LIM);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [31:0]      busy_r;
  logic [31:0]      busy_nxt_s;
  logic             b_force_s;
  logic             grant_a_s;
  logic             grant_b_s;
  logic             a_xfer_s;
  logic             b_xfer_s;
  logic             xfer_s;
  logic [4:0]       xfer_addr_s;
  logic [31:0]      xfer_data_s;
  logic             wr_nz_s;

  // Arbitration: a starved B overrides A, otherwise A has priority.
  always_comb begin
    b_force_s = i_b_valid && (cnt_r == LIM_C);
    if (b_force_s) begin
      grant_a_s = 1'b0;
    end else if (i_a_valid) begin
      grant_a_s = 1'b1;
    end else begin
      grant_a_s = 1'b0;
    end
    grant_b_s = !grant_a_s;
    o_a_ready = grant_a_s;
    o_b_ready = grant_b_s;
  end

  // Select the transferring source.
  always_comb begin
    a_xfer_s = i_a_valid && grant_a_s;
    b_xfer_s = i_b_valid && grant_b_s;
    xfer_s   = a_xfer_s || b_xfer_s;
    if (a_xfer_s) begin
      xfer_addr_s = i_a_waddr;
      xfer_data_s = i_a_wdata;
    end else if (b_xfer_s) begin
      xfer_addr_s = i_b_waddr;
      xfer_data_s = i_b_wdata;
    end else begin
      xfer_addr_s = 5'd0;
      xfer_data_s = 32'd0;
    end
    wr_nz_s = xfer_s && (xfer_addr_s != 5'd0);
  end

  // Starvation counter and scoreboard next state; a same-edge issue re-marks the register busy.
  always_comb begin
    if (b_xfer_s || !i_b_valid) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (cnt_r < LIM_C) begin
      cnt_nxt_s = cnt_r + ONE_C;
    end else begin
      cnt_nxt_s = cnt_r;
    end
    busy_nxt_s = busy_r;
    if (o_rd_wen) begin
      busy_nxt_s[o_rd_waddr] = 1'b0;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    if (i_iss_valid && (i_iss_rd != 5'd0)) begin
      busy_nxt_s[i_iss_rd] = 1'b1;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    busy_nxt_s[0] = 1'b0;
  end

  // Scoreboard queries.
  always_comb begin
`ifdef RF_WB_EARLY_CLR_EN
    o_rs1_busy = busy_r[i_rs1_raddr] && !(o_rd_wen && (o_rd_waddr == i_rs1_raddr));
    o_rs2_busy = busy_r[i_rs2_raddr] && !(o_rd_wen && (o_rd_waddr == i_rs2_raddr));
`else
    o_rs1_busy = busy_r[i_rs1_raddr];
    o_rs2_busy = busy_r[i_rs2_raddr];
`endif
  end

  // State registers and the registered RF write port.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_r      <= {CNT_W{1'b0}};
      busy_r     <= 32'd0;
      o_rd_wen   <= 1'b0;
      o_rd_waddr <= 5'd0;
      o_rd_wdata <= 32'd0;
      o_wb_unexp <= 1'b0;
    end else begin
      cnt_r      <= cnt_nxt_s;
      busy_r     <= busy_nxt_s;
      o_rd_wen   <= wr_nz_s;
      o_wb_unexp <= wr_nz_s && !busy_r[xfer_addr_s];
      if (xfer_s) begin
        o_rd_waddr <= xfer_addr_s;
        o_rd_wdata <= xfer_data_s;
      end else begin
        o_rd_waddr <= o_rd_waddr;
        o_rd_wdata <= o_rd_wdata;
      end
    end
  end

endmodule
